cpu_out_uart_tx: RTL

- Output-side peripheral for the 8-bit cpu: accepts bytes written on the cpu output port and transmits them serially as UART 8N1.
- Provides a DEPTH-entry FIFO so the cpu can issue short bursts without stalling.
- Serves as the transmit end of the cpu's I/O link. The matching receive path and the bench-side monitor decode the `tx` line back into bytes.

---
 rtl/cpu_out_uart_tx.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_out_uart_tx.sv
// UART 8N1 transmitter fed by a DEPTH-entry byte FIFO on the cpu output port; a byte pushed while idle is popped on the next edge.
// Backpressure: out_ready drops while the FIFO is full; frames run back-to-back while bytes are queued.
module cpu_out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 out_data,
  input  logic                       out_valid,
  output logic                       out_ready,
  output logic                       tx,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_nxt;
  logic [BW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          push, pop;

  assign out_ready = reset & (count != FULL);
  assign push      = out_valid & out_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // tx is registered, so it is computed from the state being entered.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (count != '0) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          tx_nxt    = 1'b0;
          state_nxt = START;
        end
      end
      START: begin
        if (baud == BAUD_LAST) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
          state_nxt   = DATA;
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            tx_nxt    = 1'b1;
            state_nxt = STOP;
          end else begin
            bit_idx_nxt = bit_idx + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud == BAUD_LAST) begin
          baud_nxt = '0;
          if (count != '0) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            tx_nxt    = 1'b0;
            state_nxt = START;
          end else begin
            tx_nxt    = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          baud_nxt = baud + BW'(1);
        end
      end
      default: begin
        tx_nxt    = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      count   <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= out_data;
  end

endmodule
